watchdog_monitor: RTL

WATCHDOG_MONITOR -- requirements
Module: watchdog_monitor

---
 rtl/watchdog_monitor.sv | 125 ++++++++++++
 1 files changed

// File: rtl/watchdog_monitor.sv
// Windowed watchdog: counts cycles between heartbeat kicks, flags a sticky fault
// on a missing (timeout) or premature (early) kick until explicitly cleared.
module watchdog_monitor (
    input  logic        CLK,
    input  logic        RSTN,
    input  logic        EN,
    input  logic        KICK,
    input  logic [15:0] TIMEOUT_LMT,
    input  logic [15:0] WIN_MIN,
    input  logic        CLR,
    output logic        WDFAIL,
    output logic [1:0]  CAUSE,
    output logic [15:0] CNT
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_FAIL = 2'd2;

    localparam logic [1:0] CAUSE_NONE    = 2'b00;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b01;
    localparam logic [1:0] CAUSE_EARLY   = 2'b10;

    logic [1:0]  state_r;
    logic [15:0] cnt_r;
    logic [1:0]  cause_r;
    logic        wdfail_r;
    logic        kick_d_r;
    logic [15:0] lmt_r;
    logic [15:0] win_r;

    logic [1:0]  state_nxt_s;
    logic [15:0] cnt_nxt_s;
    logic [1:0]  cause_nxt_s;
    logic [15:0] lmt_nxt_s;
    logic [15:0] win_nxt_s;
    logic        kick_evt_s;

    // Rising-edge kick detect; kick_d_r tracks KICK in every state so a level
    // held across arming is never seen as a fresh kick.
    always_comb begin
        kick_evt_s = KICK & ~kick_d_r;
    end

    // Next-state and datapath decision, RUN branches in strict priority order.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        cause_nxt_s = cause_r;
        lmt_nxt_s   = lmt_r;
        win_nxt_s   = win_r;
        case (state_r)
            ST_IDLE: begin
                cnt_nxt_s   = 16'd0;
                cause_nxt_s = CAUSE_NONE;
                if (EN) begin
                    state_nxt_s = ST_RUN;
                    lmt_nxt_s   = TIMEOUT_LMT;
                    win_nxt_s   = WIN_MIN;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (!EN) begin
                    state_nxt_s = ST_IDLE;
                    cnt_nxt_s   = 16'd0;
                end else if (kick_evt_s && (cnt_r < win_r)) begin
                    state_nxt_s = ST_FAIL;
                    cause_nxt_s = CAUSE_EARLY;
                end else if (kick_evt_s) begin
                    cnt_nxt_s = 16'd0;
                    lmt_nxt_s = TIMEOUT_LMT;
                    win_nxt_s = WIN_MIN;
                end else if (cnt_r == lmt_r) begin
                    state_nxt_s = ST_FAIL;
                    cause_nxt_s = CAUSE_TIMEOUT;
                end else begin
                    // Cannot overflow: the branch above stops the count at lmt_r.
                    cnt_nxt_s = cnt_r + 16'd1;
                end
            end
            ST_FAIL: begin
                if (CLR) begin
                    state_nxt_s = ST_IDLE;
                    cnt_nxt_s   = 16'd0;
                    cause_nxt_s = CAUSE_NONE;
                end else begin
                    state_nxt_s = ST_FAIL;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                cnt_nxt_s   = 16'd0;
                cause_nxt_s = CAUSE_NONE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            state_r  <= ST_IDLE;
            cnt_r    <= 16'd0;
            cause_r  <= CAUSE_NONE;
            wdfail_r <= 1'b0;
            kick_d_r <= 1'b0;
            lmt_r    <= 16'd0;
            win_r    <= 16'd0;
        end else begin
            state_r  <= state_nxt_s;
            cnt_r    <= cnt_nxt_s;
            cause_r  <= cause_nxt_s;
            wdfail_r <= (state_nxt_s == ST_FAIL);
            kick_d_r <= KICK;
            lmt_r    <= lmt_nxt_s;
            win_r    <= win_nxt_s;
        end
    end

    assign WDFAIL = wdfail_r;
    assign CAUSE  = cause_r;
    assign CNT    = cnt_r;

endmodule
